// File: rtl/hash_pkg.sv
// Shared constants and types for the byte-oriented hash: initial value,
// default round count and the sequencer state encoding.
package hash_pkg;

    localparam logic [7:0][7:0] HASH_IV         = 64'h6A09_E667_F3BC_C908;
    localparam int              HASH_NUM_ROUNDS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } hash_seq_state_t;

    function automatic logic [7:0] rotl3(input logic [7:0] x);
        return {x[4:0], x[7:5]};
    endfunction

endpackage

// File: rtl/hash_main_round.sv
// One combinational round of the hash: each state byte absorbs the message
// byte and its lane index, is rotated, and is mixed with its neighbour lane.
module hash_main_round
    import hash_pkg::*;
(
    input  logic [7:0]      M,
    input  logic [7:0][7:0] h,
    output logic [7:0][7:0] h_next
);

    for (genvar i = 0; i < 8; i++) begin : g_lane
        logic [7:0] sum;
        assign sum       = h[i] + M + 8'(i);
        assign h_next[i] = rotl3(sum) ^ h[(i + 1) % 8];
    end

endmodule

// File: rtl/hash_round_seq.sv
// Iterative hash sequencer: applies one shared round NUM_ROUNDS times per byte.
// Optional abort input enabled by defining HASH_ROUND_SEQ_ABORT_EN.
module hash_round_seq
    import hash_pkg::*;
#(
    parameter int NUM_ROUNDS = HASH_NUM_ROUNDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            msg_valid,
    input  logic [7:0]      msg_byte,
    input  logic            msg_last,
    output logic            msg_ready,
    output logic            digest_valid,
    output logic [7:0][7:0] digest,
    input  logic            digest_ready,
`ifdef HASH_ROUND_SEQ_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy
);

    localparam int                CNT_W    = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0]  LAST_RND = CNT_W'(NUM_ROUNDS - 1);

    hash_seq_state_t  state;
    hash_seq_state_t  state_next;
    logic [7:0][7:0]  h_reg;
    logic [7:0][7:0]  h_round;
    logic [7:0]       m_reg;
    logic             last_reg;
    logic [CNT_W-1:0] rnd_cnt;

    logic abort_now;
    logic accept;
    logic final_rnd;
    logic release_dig;

`ifdef HASH_ROUND_SEQ_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    // Abort outranks a coincident byte offer in IDLE.
    assign accept      = (state == IDLE) && msg_valid && !abort_now;
    assign final_rnd   = (state == ROUND) && (rnd_cnt == LAST_RND);
    assign release_dig = (state == DONE) && digest_ready;

    hash_main_round u_round (
        .M      (m_reg),
        .h      (h_reg),
        .h_next (h_round)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort_now) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept)      state_next = ROUND;
                ROUND:   if (final_rnd)   state_next = last_reg ? DONE : IDLE;
                DONE:    if (release_dig) state_next = IDLE;
                default:                  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        msg_ready    = (state == IDLE);
        digest_valid = (state == DONE);
        busy         = (state != IDLE);
    end

    assign digest = h_reg;

    // Chained state persists across the bytes of one message; only a
    // delivered digest, reset or abort brings it back to the IV.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg    <= HASH_IV;
            m_reg    <= 8'h00;
            last_reg <= 1'b0;
            rnd_cnt  <= '0;
        end else if (abort_now) begin
            h_reg    <= HASH_IV;
            rnd_cnt  <= '0;
        end else begin
            if (accept) begin
                m_reg    <= msg_byte;
                last_reg <= msg_last;
                rnd_cnt  <= '0;
            end
            if (state == ROUND) begin
                h_reg <= h_round;
                if (!final_rnd) begin
                    rnd_cnt <= rnd_cnt + 1'b1;
                end
            end
            if (release_dig) begin
                h_reg <= HASH_IV;
            end
        end
    end

endmodule

// File: tb/tb_hash_round_seq.sv
// Directed bench for hash_round_seq: table of messages plus hand sequences for
// reset mid-round, ignored offers and (with HASH_ROUND_SEQ_ABORT_EN) abort.
module tb_hash_round_seq;

    localparam int          NR = 64;
    localparam logic [63:0] IV = 64'h6A09E667F3BCC908;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            msg_valid = 1'b0;
    logic [7:0]      msg_byte = 8'h00;
    logic            msg_last = 1'b0;
    logic            msg_ready;
    logic            digest_valid;
    logic [7:0][7:0] digest;
    logic            digest_ready = 1'b0;
    logic            abort = 1'b0;
    logic            busy;

    hash_round_seq #(.NUM_ROUNDS(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .msg_valid    (msg_valid),
        .msg_byte     (msg_byte),
        .msg_last     (msg_last),
        .msg_ready    (msg_ready),
        .digest_valid (digest_valid),
        .digest       (digest),
        .digest_ready (digest_ready),
`ifdef HASH_ROUND_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int applied = 0;
    int errors  = 0;

    typedef struct {
        logic [23:0] bytes;
        int          n;
        int          hold;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_round(input logic [7:0] m, input logic [63:0] h);
        logic [63:0] o;
        logic [7:0]  t;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            t = h[8*i +: 8] + m + 8'(i);
            o[8*i +: 8] = {t[4:0], t[7:5]} ^ h[8*((i + 1) % 8) +: 8];
        end
        return o;
    endfunction

    function automatic logic [63:0] model_msg(input logic [23:0] bytes, input int n);
        logic [63:0] h;
        h = IV;
        for (int b = 0; b < n; b++)
            for (int r = 0; r < NR; r++)
                h = model_round(bytes[8*b +: 8], h);
        return h;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers each byte with msg_valid held high; returns the last acceptance edge.
    task automatic send_msg(input logic [23:0] bytes, input int n, input string name,
                            output int acc_edge);
        int prev;
        int waited;
        prev     = 0;
        acc_edge = 0;
        for (int i = 0; i < n; i++) begin
            msg_valid = 1'b1;
            msg_byte  = bytes[8*i +: 8];
            msg_last  = (i == n - 1);
            waited    = 0;
            while (!msg_ready && waited < 4 * NR) begin
                step();
                waited++;
            end
            if (!msg_ready) chk({name, "_ready_timeout"}, 72'(waited), 72'(0));
            acc_edge = edges + 1;
            if (i > 0) chk({name, "_byte_spacing"}, 72'(acc_edge - prev), 72'(NR + 1));
            prev = acc_edge;
            step();
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_dv(input int acc_edge, input string name);
        int waited;
        waited = 0;
        while (!digest_valid && waited < 4 * NR) begin
            step();
            waited++;
        end
        chk({name, "_dv_cycle"}, 72'(edges - acc_edge + 1), 72'(NR + 1));
    endtask

    task automatic take_digest(input logic [63:0] exp, input int hold, input string name);
        chk({name, "_digest"}, {8'h0, digest}, {8'h0, exp});
        for (int k = 0; k < hold; k++) begin
            step();
            chk({name, "_hold"}, {digest_valid, msg_ready, busy, digest},
                {1'b1, 1'b0, 1'b1, exp});
        end
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        chk({name, "_release"}, {digest_valid, msg_ready, busy, digest},
            {1'b0, 1'b1, 1'b0, IV});
    endtask

    task automatic run_vec(input vec_t v);
        int acc;
        send_msg(v.bytes, v.n, v.name, acc);
        wait_dv(acc, v.name);
        take_digest(v.exp, v.hold, v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0;
        vec_t        v;
        int          acc;

        d0 = model_msg(24'h000000, 1);
        vecs[0] = '{bytes: 24'h000000, n: 1, hold: 0,  exp: d0,                           name: "single_00"};
        vecs[1] = '{bytes: 24'h636261, n: 3, hold: 10, exp: model_msg(24'h636261, 3),    name: "abc_hold"};
        vecs[2] = '{bytes: 24'h000000, n: 1, hold: 0,  exp: d0,                           name: "iv_reload"};
        vecs[3] = '{bytes: 24'h0000FF, n: 1, hold: 0,  exp: model_msg(24'h0000FF, 1),    name: "single_ff"};
        vecs[4] = '{bytes: 24'h003412, n: 2, hold: 3,  exp: model_msg(24'h003412, 2),    name: "two_byte"};

        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_state", {digest_valid, msg_ready, busy, digest}, {1'b0, 1'b1, 1'b0, IV});

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset in the middle of ROUND discards the partial state.
        send_msg(24'h000000, 1, "rst_mid", acc);
        chk("rst_mid_busy", {busy, msg_ready}, {1'b1, 1'b0});
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_after", {digest_valid, msg_ready, busy, digest}, {1'b0, 1'b1, 1'b0, IV});
        v = '{bytes: 24'h000000, n: 1, hold: 0, exp: d0, name: "rst_resend"};
        run_vec(v);

        // An offer of 0xFF during ROUND must be ignored.
        send_msg(24'h000061, 1, "ignore", acc);
        repeat (10) step();
        msg_valid = 1'b1;
        msg_byte  = 8'hFF;
        msg_last  = 1'b1;
        repeat (5) step();
        chk("ignore_during_round", {busy, msg_ready}, {1'b1, 1'b0});
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        wait_dv(acc, "ignore");
        take_digest(model_msg(24'h000061, 1), 0, "ignore");

`ifdef HASH_ROUND_SEQ_ABORT_EN
        send_msg(24'h000000, 1, "abort_done", acc);
        wait_dv(acc, "abort_done");
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done_after", {digest_valid, msg_ready, busy, digest}, {1'b0, 1'b1, 1'b0, IV});
        msg_valid = 1'b1;
        msg_byte  = 8'h55;
        msg_last  = 1'b1;
        abort     = 1'b1;
        step();
        abort     = 1'b0;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        chk("abort_wins_idle", {busy, msg_ready}, {1'b0, 1'b1});
        v = '{bytes: 24'h000000, n: 1, hold: 0, exp: d0, name: "abort_resend"};
        run_vec(v);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
